// File: rtl/lsb_mem_unit_if.sv
// Bundle of the ROB request/result handshake and the byte-wide memory port
// used by lsb_mem_unit.
//   rdy                global ready (low = stall)
//   lsb_enable, lsb_rob_index, lsb_opcode, lsb_ls_addr, lsb_s_val
//                      request from the ROB head
//   lsb_ls_enable, lsb_rob_index_out, lsb_l_data
//                      one-cycle completion back to the ROB
//   mem_a, mem_wr, mem_dout, mem_din
//                      byte memory port (mem_din is one cycle behind mem_a)
//   busy               unit is not idle
// modport slave is the unit itself; modport master is its environment.
interface lsb_mem_unit_if;
  logic        rdy;
  logic        lsb_enable;
  logic [5:0]  lsb_rob_index;
  logic [5:0]  lsb_opcode;
  logic [31:0] lsb_ls_addr;
  logic [31:0] lsb_s_val;
  logic        lsb_ls_enable;
  logic [5:0]  lsb_rob_index_out;
  logic [31:0] lsb_l_data;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        busy;

  modport slave (
    input  rdy, lsb_enable, lsb_rob_index, lsb_opcode, lsb_ls_addr, lsb_s_val,
    input  mem_din,
    output lsb_ls_enable, lsb_rob_index_out, lsb_l_data,
    output mem_a, mem_wr, mem_dout, busy
  );

  modport master (
    output rdy, lsb_enable, lsb_rob_index, lsb_opcode, lsb_ls_addr, lsb_s_val,
    output mem_din,
    input  lsb_ls_enable, lsb_rob_index_out, lsb_l_data,
    input  mem_a, mem_wr, mem_dout, busy
  );
endinterface

// File: rtl/lsb_mem_unit.sv
// Commit-time load/store unit. Executes one committed load or store from the
// ROB head as 1, 2 or 4 serial byte accesses on a byte-wide memory port and
// returns a one-cycle completion (with extended load data) to the ROB.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; aborts any op in flight
//   bus  lsb_mem_unit_if.slave: ROB request/result, memory port, rdy, busy

// Fallback encodings when config.vh has not been included ahead of this file.
`ifndef LB
`define LB  6'd1
`endif
`ifndef LH
`define LH  6'd2
`endif
`ifndef LW
`define LW  6'd3
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif
`ifndef SB
`define SB  6'd6
`endif
`ifndef SH
`define SH  6'd7
`endif
`ifndef SW
`define SW  6'd8
`endif

module lsb_mem_unit (
  input logic           clk,
  input logic           rst,
  lsb_mem_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  tag_q, tag_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sval_q, sval_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  k_q, k_d;
  logic        pend_q, pend_d;
  logic [31:0] last_a_q, last_a_d;
  logic [7:0]  last_dout_q, last_dout_d;

  logic [2:0]  req_n;
  logic        op_store;
  logic [31:0] cur_a;
  logic [31:0] sval_sh;
  logic [31:0] result;

  // Byte count of the incoming request; 0 marks an unsupported opcode.
  always_comb begin
    req_n = 3'd0;
    case (bus.lsb_opcode)
      `LB, `LBU, `SB: req_n = 3'd1;
      `LH, `LHU, `SH: req_n = 3'd2;
      `LW, `SW:       req_n = 3'd4;
      default:        req_n = 3'd0;
    endcase
  end

  always_comb begin
    op_store = 1'b0;
    case (op_q)
      `SB, `SH, `SW: op_store = 1'b1;
      default:       op_store = 1'b0;
    endcase
  end

  assign cur_a   = addr_q + {29'd0, k_q};
  assign sval_sh = sval_q >> {k_q, 3'b000};

  always_comb begin
    result = '0;
    case (op_q)
      `LB:       result = {{24{data_q[7]}}, data_q[7:0]};
      `LH:       result = {{16{data_q[15]}}, data_q[15:0]};
      `LBU:      result = {24'd0, data_q[7:0]};
      `LHU:      result = {16'd0, data_q[15:0]};
      `LW:       result = data_q;
      default:   result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      sval_q      <= '0;
      data_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      last_a_q    <= '0;
      last_dout_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      sval_q      <= sval_d;
      data_q      <= data_d;
      n_q         <= n_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      last_a_q    <= last_a_d;
      last_dout_q <= last_dout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    op_d        = op_q;
    addr_d      = addr_q;
    sval_d      = sval_q;
    data_d      = data_q;
    n_d         = n_q;
    k_d         = k_q;
    pend_d      = pend_q;
    last_a_d    = last_a_q;
    last_dout_d = last_dout_q;

    // mem_din answers the address issued one cycle earlier, i.e. byte k-1,
    // so the capture must happen even while rdy holds the FSM.
    if (pend_q) begin
      data_d[{k_q - 3'd1, 3'b000} +: 8] = bus.mem_din;
      pend_d = 1'b0;
    end

    if (bus.rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.lsb_enable) begin
            tag_d   = bus.lsb_rob_index;
            op_d    = bus.lsb_opcode;
            addr_d  = bus.lsb_ls_addr;
            sval_d  = bus.lsb_s_val;
            n_d     = req_n;
            k_d     = '0;
            data_d  = '0;
            state_d = (req_n == 3'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          last_a_d = cur_a;
          if (op_store) last_dout_d = sval_sh[7:0];
          else          pend_d      = 1'b1;
          k_d = k_q + 3'd1;
          if (k_q == n_q - 3'd1) state_d = op_store ? DONE : DRAIN;
        end
        DRAIN:   state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy              = (state_q != IDLE);
    bus.lsb_ls_enable     = (state_q == DONE);
    bus.lsb_rob_index_out = (state_q == DONE) ? tag_q : '0;
    bus.lsb_l_data        = (state_q == DONE) ? result : '0;
    bus.mem_a             = (state_q == RUN) ? cur_a : last_a_q;
    bus.mem_wr            = (state_q == RUN) && op_store && bus.rdy;
    bus.mem_dout          = ((state_q == RUN) && op_store) ? sval_sh[7:0] : last_dout_q;
  end
endmodule

// File: doc/lsb_mem_unit.md
# lsb_mem_unit

Commit-time load/store execution unit between the reorder buffer and the byte-wide unified memory port. Takes one non-speculative load or store from the ROB head and runs it as 1, 2 or 4 serial byte accesses. Returns the extended load data, or a store completion, to the ROB as a one-cycle result pulse.

## Interface
- No parameters. Opcode encodings are the `LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW macros from config.vh.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = stall
- lsb_enable  in  1  request strobe from ROB; sampled only in IDLE
- lsb_rob_index  in  6  ROB tag of the request
- lsb_opcode  in  6  load/store opcode
- lsb_ls_addr  in  32  effective byte address
- lsb_s_val  in  32  store data; low bytes used
- lsb_ls_enable  out  1  completion pulse to ROB
- lsb_rob_index_out  out  6  tag of the completed op
- lsb_l_data  out  32  extended load result; 0 for stores
- mem_a  out  32  memory byte address
- mem_wr  out  1  1 = write this cycle
- mem_dout  out  8  write byte
- mem_din  in  8  read byte; returns data for the address presented one cycle earlier
- busy  out  1  high whenever state != IDLE

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE, with lsb_enable=1 and rdy=1:
  - Latch tag, opcode, address and store value.
  - Set byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
  - Clear k (issue counter) and the data register, then go to RUN.
- A request with any other opcode is accepted and completes with lsb_l_data=0 and no memory access, going IDLE->DONE.
- RUN, each rdy-high cycle:
  - Drive mem_a = addr+k, computed mod 2^32, so the address wraps.
  - Store: mem_wr=1, mem_dout = byte k of the store value (little-endian).
  - Load: mem_wr=0 and set pend.
  - Then k+1. When k reaches N-1: stores go to DONE, loads go to DRAIN.
- Read capture: in any cycle with pend=1, whatever rdy is, write mem_din into data byte k-1 and clear pend.
- DRAIN: capture the last byte, then go to DONE.
- DONE:
  - Assert lsb_ls_enable=1 for exactly one cycle, with lsb_rob_index_out = tag.
  - Loads: lsb_l_data = LB/LH sign-extended from bit 7/15; LBU/LHU zero-extended; LW raw. Stores: lsb_l_data = 0.
  - Go to IDLE.
- lsb_enable while busy is ignored; the ROB never issues a second request before completion.
- No flush input. Requests are committed, so an in-flight op always finishes. Only rst aborts.
- Misaligned addresses need no special handling; bytes are accessed serially.

## Timing
- Reset: state IDLE, k=0, pend=0, data=0. All outputs 0: lsb_ls_enable, lsb_rob_index_out, lsb_l_data, mem_a, mem_wr, mem_dout, busy.
- rst mid-operation: abort with no completion pulse. A write already performed is not undone.
- Request sampled at edge E0. Bytes are issued in cycles E0+1 .. E0+N.
- Store: lsb_ls_enable is high in cycle E0+N+1, so total latency is N+1.
- Load: last capture in E0+N+1; lsb_ls_enable is high in cycle E0+N+2.
- Fastest back-to-back: a new request can be accepted in the cycle after the DONE pulse.
- rdy low:
  - state, k and outputs hold, except that mem_wr is forced to 0 combinationally.
  - the read capture of an outstanding pend still occurs.
  - the DONE pulse is held until rdy returns, then lasts exactly one rdy-high cycle.
- Outside RUN, mem_wr=0 and mem_a holds its last value.
- lsb_l_data and lsb_rob_index_out are valid only while lsb_ls_enable=1.

## Test plan
- LW, addr 0x100, memory bytes 11 22 33 44, tag 5:
  - mem_a = 0x100..0x103 in E0+1..E0+4.
  - lsb_ls_enable in E0+6 with tag 5 and data 0x44332211.
- LB and LBU, addr 0x200, byte 0x80:
  - LB returns 0xFFFFFF80.
  - LBU returns 0x00000080.
  - Both take 3-cycle latency.
- SH, addr 0xFFFFFFFF, value 0xABCD1234:
  - writes 0x34 @0xFFFFFFFF, then 0x12 @0x00000000 (wrap).
  - mem_wr is high for exactly 2 cycles.
  - pulse in E0+3 with l_data=0.
- rdy dropped for 3 cycles during the second byte of an LW:
  - mem_wr stays 0.
  - no byte is lost or duplicated.
  - the result equals the no-stall result, delayed 3 cycles.
- Second lsb_enable asserted while busy: ignored; exactly one completion pulse.
- rst asserted in RUN of an SW after 2 bytes:
  - all outputs are 0 next cycle.
  - no lsb_ls_enable.
  - the next request completes normally.
